// File: rtl/lsu_ctrl.sv
// Load/store unit controller: checks size/alignment of the MW-stage access, issues one
// bus transaction per legal access, waits for mem_ack with a timeout, and extends load data.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en_MW,
  input  logic        wr_en_MW,
  input  logic [2:0]  size_MW,
  input  logic [31:0] addr_MW,
  input  logic [31:0] wdata_MW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [2:0]  size_q;
  logic [1:0]  lo_q;

  logic        size_ok;
  logic        aligned;
  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b0;
    be_c    = 4'b0000;
    wdata_c = wdata_MW;
    case (size_MW)
      3'b000, 3'b100: begin
        size_ok = (size_MW[2] == 1'b0) || !wr_en_MW;
        aligned = 1'b1;
        be_c    = 4'b0001 << addr_MW[1:0];
        wdata_c = {4{wdata_MW[7:0]}};
      end
      3'b001, 3'b101: begin
        size_ok = (size_MW[2] == 1'b0) || !wr_en_MW;
        aligned = !addr_MW[0];
        be_c    = 4'b0011 << {addr_MW[1], 1'b0};
        wdata_c = {2{wdata_MW[15:0]}};
      end
      3'b010: begin
        size_ok = 1'b1;
        aligned = (addr_MW[1:0] == 2'b00);
        be_c    = 4'b1111;
        wdata_c = wdata_MW;
      end
      default: size_ok = 1'b0;
    endcase
    legal = (rd_en_MW ^ wr_en_MW) && size_ok && aligned;
  end

  // Reset gates these so the pipeline is never frozen or trapped while held in reset.
  assign misalign = reset && (state == IDLE) && (rd_en_MW || wr_en_MW) && !legal;
  assign stall    = reset && (((state == IDLE) && legal) || (state == BUSY));

  always_comb begin
    case (lo_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      size_q    <= 3'b000;
      lo_q      <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            state     <= BUSY;
            wait_cnt  <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= wr_en_MW;
            mem_addr  <= {addr_MW[31:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
            size_q    <= size_MW;
            lo_q      <= addr_MW[1:0];
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we) load_data <= load_ext;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
